ram_port_arbiter: RTL and testbench

//  Two-requester arbiter for the single-port 1024x32 program/data RAM.

---
 rtl/ram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester arbiter in front of the single-port program/data RAM.
// Port 0 is the CPU data path, port 1 is instruction fetch / loader.
// Round-robin between ports, optional per-port lock for atomic RMW,
// and read data returned to whichever port issued the read.
//
// state | meaning
// ------+-----------------------------------------------------------
// ARB   | normal round-robin arbitration between both ports
// LOCK0 | port 0 holds exclusive ownership, port 1 stalled
// LOCK1 | port 1 holds exclusive ownership, port 0 stalled
module ram_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;   // port granted most recently; the other wins a tie
    logic   rsp_valid;  // a read was granted last cycle
    logic   rsp_port;   // which port owns that read

    // Grant decision; gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            case (state)
                ARB: begin
                    if (m0_req && m1_req) begin
                        if (last_gnt) m0_gnt = 1'b1;
                        else          m1_gnt = 1'b1;
                    end else if (m0_req) begin
                        m0_gnt = 1'b1;
                    end else if (m1_req) begin
                        m1_gnt = 1'b1;
                    end
                end
                LOCK0:   m0_gnt = m0_req;
                LOCK1:   m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    // Arbitration FSM, round-robin pointer and read-response ownership.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB;
            last_gnt  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
        end else begin
            if (m0_gnt) last_gnt <= 1'b0;
            if (m1_gnt) last_gnt <= 1'b1;

            rsp_valid <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
            rsp_port  <= m1_gnt;

            case (state)
                ARB: begin
                    if (m0_gnt && m0_lock)      state <= LOCK0;
                    else if (m1_gnt && m1_lock) state <= LOCK1;
                end
                LOCK0:   if (!m0_lock) state <= ARB;
                LOCK1:   if (!m1_lock) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    // RAM drive muxed from the granted port; idle cycles drive zeros,
    // which makes the RAM do a harmless read that nobody reports.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        if (m0_gnt) begin
            ram_wr_en   = m0_we;
            ram_address = m0_addr;
            ram_data_in = m0_wdata;
        end else if (m1_gnt) begin
            ram_wr_en   = m1_we;
            ram_address = m1_addr;
            ram_data_in = m1_wdata;
        end
    end

    // Steer the RAM's registered read data to the port that owns it.
    always_comb begin
        m0_rvalid = rsp_valid && !rsp_port;
        m1_rvalid = rsp_valid &&  rsp_port;
        m0_rdata  = m0_rvalid ? ram_data_out : '0;
        m1_rdata  = m1_rvalid ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural 1024x32 RAM, a read-response
// scoreboard fed from observed grants, and per-scenario directed checks.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m0_req, m0_we, m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt, m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req, m1_we, m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    int n_checks = 0;
    int n_pass   = 0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wr_en(ram_wr_en), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Behavioural single-port RAM with a registered read.
    logic [DATA_W-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    // Scoreboard: bench-side RAM contents and expected read responses.
    logic [DATA_W-1:0] shadow [0:1023];
    logic [32:0]       sb [$];
    logic              mon_en = 1'b0;
    logic              rst_at_edge = 1'b0;
    logic              ev0, ev1;
    logic [DATA_W-1:0] ed0, ed1;
    logic [32:0]       ent;

    always @(posedge clk) rst_at_edge <= rst_n;

    always @(negedge clk) begin
        if (mon_en) begin
            ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
            if (!rst_at_edge) begin
                sb.delete();
            end else if (sb.size() > 0) begin
                ent = sb.pop_front();
                if (ent[32]) begin ev1 = 1'b1; ed1 = ent[31:0]; end
                else         begin ev0 = 1'b1; ed0 = ent[31:0]; end
            end
            n_checks++;
            if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {ev0, ev1, ed0, ed1})
                $display("FAIL sb_rsp @%0t: got v0=%b v1=%b d0=%h d1=%h want v0=%b v1=%b d0=%h d1=%h",
                         $time, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, ev0, ev1, ed0, ed1);
            else
                n_pass++;
            if (rst_n && m0_gnt) begin
                if (m0_we) shadow[m0_addr] = m0_wdata;
                else       sb.push_back({1'b0, shadow[m0_addr]});
            end
            if (rst_n && m1_gnt) begin
                if (m1_we) shadow[m1_addr] = m1_wdata;
                else       sb.push_back({1'b1, shadow[m1_addr]});
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive0(input logic req, we, lock, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        m0_req = req; m0_we = we; m0_lock = lock; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drive1(input logic req, we, lock, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        m1_req = req; m1_we = we; m1_lock = lock; m1_addr = a; m1_wdata = d;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // requests (including a write) held high during reset must be ignored
        drive0(1, 1, 0, 10'd12, 32'h1111_1111);
        drive1(1, 0, 0, 10'd13, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {m0_gnt, m1_gnt});
        else n_pass++;
        n_checks++;
        if (ram_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", ram_wr_en);
        else n_pass++;
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid});
        else n_pass++;
        step();
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        step();
        drive0(1, 0, 0, 10'd0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL t1_gnt: got %b want 10", {m0_gnt, m1_gnt});
        else n_pass++;
        n_checks++;
        if ({ram_wr_en, ram_address} !== {1'b0, 10'd0})
            $display("FAIL t1_ram: got we=%b a=%0d want we=0 a=0", ram_wr_en, ram_address);
        else n_pass++;
        step();
        drive0(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10) $display("FAIL t1_rvalid: got %b want 10", {m0_rvalid, m1_rvalid});
        else n_pass++;
        n_checks++;
        if (m0_rdata !== init_word(0)) $display("FAIL t1_rdata: got %h want %h", m0_rdata, init_word(0));
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic was0, was1;
        do_reset();
        step();
        drive0(1, 0, 0, 10'd100, '0);
        drive1(1, 0, 0, 10'd200, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL rr_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if ({m0_rvalid, m1_rvalid} !== (((i - 1) % 2 == 0) ? 2'b10 : 2'b01))
                    $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {m0_rvalid, m1_rvalid},
                             ((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
                else n_pass++;
            end
            was0 = m0_gnt;
            was1 = m1_gnt;
            step();
            if (was0) m0_addr = m0_addr + 10'd1;
            if (was1) m1_addr = m1_addr + 10'd1;
        end
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL rr_last_rvalid: got %b want 01", {m0_rvalid, m1_rvalid});
        else n_pass++;
    endtask

    task automatic test_write_then_read_top();
        step();
        drive1(1, 1, 0, 10'd1023, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if ({m1_gnt, ram_wr_en, ram_address, ram_data_in} !== {1'b1, 1'b1, 10'd1023, 32'hDEAD_BEEF})
            $display("FAIL wr_drive: got g=%b we=%b a=%0d d=%h want g=1 we=1 a=1023 d=deadbeef",
                     m1_gnt, ram_wr_en, ram_address, ram_data_in);
        else n_pass++;
        step();
        drive1(0, 0, 0, '0, '0);
        drive0(1, 0, 0, 10'd1023, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m0_rvalid, m1_rvalid} !== 3'b100)
            $display("FAIL wr_no_rvalid: got g0=%b v0=%b v1=%b want 1 0 0", m0_gnt, m0_rvalid, m1_rvalid);
        else n_pass++;
        step();
        drive0(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEAD_BEEF})
            $display("FAIL rd_1023: got v=%b d=%h want v=1 d=deadbeef", m0_rvalid, m0_rdata);
        else n_pass++;
    endtask

    task automatic test_lock();
        do_reset();
        step();
        drive0(1, 0, 1, 10'd5, '0);
        drive1(1, 0, 0, 10'd7, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL lock_c0: got %b want 10", {m0_gnt, m1_gnt});
        else n_pass++;
        step();
        drive0(1, 1, 1, 10'd5, 32'h1234_5678);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL lock_c1: got %b want 10", {m0_gnt, m1_gnt});
        else n_pass++;
        step();
        drive0(1, 0, 0, 10'd5, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid} !== 3'b100)
            $display("FAIL lock_c2: got g=%b v0=%b want g=10 v0=0", {m0_gnt, m1_gnt}, m0_rvalid);
        else n_pass++;
        step();
        drive0(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL lock_release: got %b want 01", {m0_gnt, m1_gnt});
        else n_pass++;
        n_checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL lock_rmw_data: got v=%b d=%h want v=1 d=12345678", m0_rvalid, m0_rdata);
        else n_pass++;
        step();
        drive1(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, init_word(7)})
            $display("FAIL lock_m1_data: got v=%b d=%h want v=1 d=%h", m1_rvalid, m1_rdata, init_word(7));
        else n_pass++;
    endtask

    task automatic test_reset_drops_read();
        do_reset();
        step();
        drive0(1, 0, 0, 10'd3, '0);
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1) $display("FAIL rd_before_rst: got %b want 1", m0_gnt);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        drive0(1, 1, 0, 10'd9, 32'hBAD0_BAD0);
        drive1(1, 0, 0, 10'd4, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_gnt, m1_gnt, ram_wr_en, m0_rvalid, m1_rvalid} !== 5'b00000)
                $display("FAIL in_rst[%0d]: got g0=%b g1=%b we=%b v0=%b v1=%b want all 0",
                         i, m0_gnt, m1_gnt, ram_wr_en, m0_rvalid, m1_rvalid);
            else n_pass++;
            step();
        end
        rst_n = 1'b1;
        drive0(1, 0, 0, 10'd9, '0);
        drive1(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1) $display("FAIL post_rst_gnt: got %b want 1", m0_gnt);
        else n_pass++;
        step();
        drive0(0, 0, 0, '0, '0);
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, init_word(9)})
            $display("FAIL no_write_in_rst: got v=%b d=%h want v=1 d=%h", m0_rvalid, m0_rdata, init_word(9));
        else n_pass++;
    endtask

    task automatic test_idle();
        step();
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_gnt, m1_gnt, ram_wr_en, ram_address, ram_data_in, m0_rvalid, m1_rvalid} !== '0)
                $display("FAIL idle[%0d]: got g=%b%b we=%b a=%0d d=%h v=%b%b want all 0", i,
                         m0_gnt, m1_gnt, ram_wr_en, ram_address, ram_data_in, m0_rvalid, m1_rvalid);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        rst_n = 1'b0;
        drive0(0, 0, 0, '0, '0);
        drive1(0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        test_reset();
        test_single_read();
        test_round_robin();
        test_write_then_read_top();
        test_lock();
        test_reset_drops_read();
        test_idle();

        step();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
